// File: rtl/soh_pkg.sv
// Shared select codes and widths for the second ALU operand path.
// Imported by second_operand_mux and second_operand_handler.
package soh_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] SEL_PB    = 3'd0;
    localparam logic [2:0] SEL_IMMI  = 3'd1;
    localparam logic [2:0] SEL_IMMS  = 3'd2;
    localparam logic [2:0] SEL_IMMU  = 3'd3;
    localparam logic [2:0] SEL_PC    = 3'd4;
    localparam logic [2:0] SEL_SHAMT = 3'd5;
    localparam logic [2:0] SEL_IMMIZ = 3'd6;
    localparam logic [2:0] SEL_FOUR  = 3'd7;

    localparam logic [XLEN-1:0] CONST_FOUR = 32'h0000_0004;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/second_operand_mux.sv
// Purely combinational selection of the second ALU operand from the
// register, immediate, PC and constant sources according to si.
module second_operand_mux
    import soh_pkg::*;
(
    input  logic [2:0]      si,
    input  logic [XLEN-1:0] pb,
    input  logic [11:0]     imm12_i,
    input  logic [11:0]     imm12_s,
    input  logic [XLEN-1:0] pc,
    input  logic [19:0]     imm20,
    output logic [XLEN-1:0] nxt
);

    always_comb begin
        nxt = '0;
        case (si)
            SEL_PB:    nxt = pb;
            SEL_IMMI:  nxt = sext12(imm12_i);
            SEL_IMMS:  nxt = sext12(imm12_s);
            SEL_IMMU:  nxt = {imm20, 12'b0};
            SEL_PC:    nxt = pc;
            // Only the low five bits are a legal RV32 shift amount.
            SEL_SHAMT: nxt = {27'b0, imm12_i[4:0]};
            SEL_IMMIZ: nxt = {20'b0, imm12_i};
            SEL_FOUR:  nxt = CONST_FOUR;
            default:   nxt = '0;
        endcase
    end

endmodule

// File: rtl/second_operand_handler.sv
// Registered second ALU operand N with load enable and async reset.
// Define SOH_COMB_OUT_EN to also expose the unregistered select as N_comb.
module second_operand_handler
    import soh_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      Si,
    input  logic [XLEN-1:0] PB,
    input  logic [11:0]     imm12_I,
    input  logic [11:0]     imm12_S,
    input  logic [XLEN-1:0] PC,
    input  logic [19:0]     imm20,
`ifdef SOH_COMB_OUT_EN
    output logic [XLEN-1:0] N_comb,
`endif
    output logic [XLEN-1:0] N
);

    logic [XLEN-1:0] nxt;
    logic [XLEN-1:0] n_d;
    logic [XLEN-1:0] n_q;

    second_operand_mux u_mux (
        .si      (Si),
        .pb      (PB),
        .imm12_i (imm12_I),
        .imm12_s (imm12_S),
        .pc      (PC),
        .imm20   (imm20),
        .nxt     (nxt)
    );

    always_comb begin
        n_d = n_q;
        if (en) begin
            n_d = nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end

    assign N = n_q;

`ifdef SOH_COMB_OUT_EN
    // Zero-latency tap, deliberately independent of rst and en.
    assign N_comb = nxt;
`endif

endmodule

// File: tb/tb_second_operand_handler.sv
// Directed self-checking bench for second_operand_handler.
// Honours SOH_COMB_OUT_EN to also check the combinational tap.
module tb_second_operand_handler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  Si;
    logic [31:0] PB;
    logic [11:0] imm12_I;
    logic [11:0] imm12_S;
    logic [31:0] PC;
    logic [19:0] imm20;
    logic [31:0] N;
`ifdef SOH_COMB_OUT_EN
    logic [31:0] N_comb;
`endif

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    second_operand_handler dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .Si      (Si),
        .PB      (PB),
        .imm12_I (imm12_I),
        .imm12_S (imm12_S),
        .PC      (PC),
        .imm20   (imm20),
`ifdef SOH_COMB_OUT_EN
        .N_comb  (N_comb),
`endif
        .N       (N)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Driver: advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic common_inputs();
        PB      = 32'h0431FFEA;
        imm12_I = 12'hC0C;
        imm12_S = 12'h70F;
        PC      = 32'hC431FFEA;
        imm20   = 20'hEC44F;
        en      = 1'b1;
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp_v;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        Si  = 3'd0;
        common_inputs();

        // Reset value before any clock edge
        #2;
        check_eq("reset_no_edge", N, 32'h0);
        step();
        check_eq("reset_held_edge", N, 32'h0);
        rst = 1'b0;

        // Sweep all select codes
        exp_q = '{32'h0431FFEA, 32'hFFFFFC0C, 32'h0000070F, 32'hEC44F000,
                  32'hC431FFEA, 32'h0000000C, 32'h00000C0C, 32'h00000004};
        prev = 32'h0;
        for (int i = 0; i < 8; i++) begin
            Si = 3'(i);
            exp_v = exp_q.pop_front();
            #1;
            check_eq($sformatf("latency_si%0d", i), N, prev);
`ifdef SOH_COMB_OUT_EN
            check_eq($sformatf("comb_si%0d", i), N_comb, exp_v);
`endif
            step();
            check_eq($sformatf("sweep_si%0d", i), N, exp_v);
            prev = exp_v;
        end

        // Sign-extension boundary
        Si = 3'd1;
        imm12_I = 12'h7FF;
        step();
        check_eq("sext_7ff", N, 32'h000007FF);
        imm12_I = 12'h800;
        step();
        check_eq("sext_800", N, 32'hFFFFF800);
        Si = 3'd6;
        step();
        check_eq("zext_800", N, 32'h00000800);
        common_inputs();

        // Hold with en low
        Si = 3'd0;
        step();
        check_eq("hold_load", N, 32'h0431FFEA);
        en = 1'b0;
        Si = 3'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("hold_cyc%0d", i), N, 32'h0431FFEA);
        end

        // Reset mid-operation
        en = 1'b1;
        Si = 3'd3;
        step();
        check_eq("pre_reset_load", N, 32'hEC44F000);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_reset_async", N, 32'h0);
`ifdef SOH_COMB_OUT_EN
        check_eq("comb_during_reset", N_comb, 32'hEC44F000);
`endif
        step();
        check_eq("reset_beats_en", N, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_eq("after_release_no_edge", N, 32'h0);
        step();
        check_eq("first_load_after_reset", N, 32'hEC44F000);

`ifdef SOH_COMB_OUT_EN
        // Combinational tap leads the register by one edge
        Si = 3'd0;
        step();
        Si = 3'd7;
        #1;
        check_eq("comb_same_cycle", N_comb, 32'h00000004);
        check_eq("reg_not_yet", N, 32'h0431FFEA);
        step();
        check_eq("reg_after_edge", N, 32'h00000004);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
